edge_cfg_axil_arbiter: RTL

- Round-robin arbiter that shares the single AXI4-Lite slave port of the edge-detection core (four 32-bit config/status registers) between NUM_REQ local requesters, e.g. the PS config path and the frame sequencer.
- Each requester uses a simple req/ready plus rsp pulse interface; the block serialises the requests into AXI4-Lite master transactions, one outstanding at a time.

---
 rtl/edge_cfg_axil_arbiter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/edge_cfg_axil_arbiter.sv
// Round-robin arbiter that serialises NUM_REQ req/ready requesters onto one AXI4-Lite master port.
// Optional macro EDGE_CFG_ARB_ADDR_CHECK_EN rejects out-of-range or misaligned addresses locally with SLVERR.
module edge_cfg_axil_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 4
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic [1:0]                     rsp_resp,
  output logic [ADDR_WIDTH-1:0]          M_AXI_AWADDR,
  output logic [2:0]                     M_AXI_AWPROT,
  output logic                           M_AXI_AWVALID,
  input  logic                           M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]          M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0]        M_AXI_WSTRB,
  output logic                           M_AXI_WVALID,
  input  logic                           M_AXI_WREADY,
  input  logic [1:0]                     M_AXI_BRESP,
  input  logic                           M_AXI_BVALID,
  output logic                           M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]          M_AXI_ARADDR,
  output logic [2:0]                     M_AXI_ARPROT,
  output logic                           M_AXI_ARVALID,
  input  logic                           M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]          M_AXI_RDATA,
  input  logic [1:0]                     M_AXI_RRESP,
  input  logic                           M_AXI_RVALID,
  output logic                           M_AXI_RREADY
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || DATA_WIDTH != 32 || NUM_REGS < 1) begin : g_cfg_err
    $error("edge_cfg_axil_arbiter: unsupported parameter set");
  end

  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA} state_t;

  state_t                  r_state, w_next;
  logic [PW-1:0]           r_ptr, r_gnt;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic                    r_aw_done, r_w_done;
  logic [NUM_REQ-1:0]      r_rsp_valid;
  logic [DATA_WIDTH-1:0]   r_rsp_rdata;
  logic [1:0]              r_rsp_resp;

  logic [ADDR_WIDTH-1:0]   w_addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0]   w_wdata_arr [NUM_REQ];
  logic                    w_any, w_grant, w_addr_bad;
  logic [PW-1:0]           w_sel;
  int unsigned             w_idx;
  logic [ADDR_WIDTH-1:0]   w_sel_addr;
  logic [DATA_WIDTH-1:0]   w_sel_wdata;
  logic                    w_sel_we;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      w_wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // First active requester at or after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    w_idx = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_idx = 32'(r_ptr) + i;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (!w_any && req_valid[w_idx[PW-1:0]]) begin
        w_any = 1'b1;
        w_sel = w_idx[PW-1:0];
      end
    end
  end

  assign w_grant     = (r_state == IDLE) && w_any;
  assign w_sel_addr  = w_addr_arr[w_sel];
  assign w_sel_wdata = w_wdata_arr[w_sel];
  assign w_sel_we    = req_we[w_sel];

`ifdef EDGE_CFG_ARB_ADDR_CHECK_EN
  assign w_addr_bad = (w_sel_addr[1:0] != 2'b00) ||
                      ((32'(w_sel_addr) >> 2) >= 32'(NUM_REGS));
`else
  assign w_addr_bad = 1'b0;
`endif

  always_comb begin
    req_ready = '0;
    if (w_grant) req_ready[w_sel] = 1'b1;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= '0;
    end else begin
      r_state     <= w_next;
      r_rsp_valid <= '0;
      if (w_grant) begin
        r_gnt     <= w_sel;
        r_ptr     <= (w_sel == PW'(NUM_REQ - 1)) ? '0 : w_sel + 1'b1;
        r_addr    <= w_sel_addr;
        r_wdata   <= w_sel_wdata;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        // Rejected addresses complete locally one cycle after grant.
        if (w_addr_bad) begin
          r_rsp_valid[w_sel] <= 1'b1;
          r_rsp_rdata        <= '0;
          r_rsp_resp         <= 2'b10;
        end
      end
      if (r_state == WADDR) begin
        if (M_AXI_AWREADY) r_aw_done <= 1'b1;
        if (M_AXI_WREADY)  r_w_done  <= 1'b1;
      end
      if (r_state == WRESP && M_AXI_BVALID) begin
        r_rsp_valid[r_gnt] <= 1'b1;
        r_rsp_rdata        <= '0;
        r_rsp_resp         <= M_AXI_BRESP;
      end
      if (r_state == RDATA && M_AXI_RVALID) begin
        r_rsp_valid[r_gnt] <= 1'b1;
        r_rsp_rdata        <= M_AXI_RDATA;
        r_rsp_resp         <= M_AXI_RRESP;
      end
    end
  end

  always_comb begin
    w_next        = r_state;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant && !w_addr_bad) w_next = w_sel_we ? WADDR : RADDR;
      end
      WADDR: begin
        M_AXI_AWVALID = !r_aw_done;
        M_AXI_WVALID  = !r_w_done;
        if ((r_aw_done || M_AXI_AWREADY) && (r_w_done || M_AXI_WREADY)) w_next = WRESP;
      end
      WRESP: begin
        M_AXI_BREADY = 1'b1;
        if (M_AXI_BVALID) w_next = IDLE;
      end
      RADDR: begin
        M_AXI_ARVALID = 1'b1;
        if (M_AXI_ARREADY) w_next = RDATA;
      end
      RDATA: begin
        M_AXI_RREADY = 1'b1;
        if (M_AXI_RVALID) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign M_AXI_AWADDR = r_addr;
  assign M_AXI_ARADDR = r_addr;
  assign M_AXI_WDATA  = r_wdata;
  assign M_AXI_AWPROT = '0;
  assign M_AXI_ARPROT = '0;
  assign M_AXI_WSTRB  = '1;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_rdata    = r_rsp_rdata;
  assign rsp_resp     = r_rsp_resp;

endmodule
